// File: rtl/ssg_pkg.sv
// Shared types and constants for the seven-segment score controller.
package ssg_pkg;

    localparam logic [3:0]  DIGIT_DASH = 4'hA;
    localparam logic [13:0] BCD_MAX    = 14'd9999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } ssg_ctrl_state_t;

    // Index 0 = ones, 3 = thousands.
    typedef logic [3:0][3:0] bcd4_t;

endpackage

// File: rtl/ssg_score_ctrl_dabble.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift
// {bcd, bin} left by one bit.
module bcd_dabble_step #(
    parameter int W = 14
) (
    input  logic [15:0]  bcd_in,
    input  logic [W-1:0] bin_in,
    output logic [15:0]  bcd_out,
    output logic [W-1:0] bin_out
);

    logic [15:0] bcd_adj;

    // Per-nibble add-3 correction followed by the combined left shift
    always_comb begin
        bcd_adj = bcd_in;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bcd_in[i*4 +: 4] >= 4'd5) begin
                bcd_adj[i*4 +: 4] = bcd_in[i*4 +: 4] + 4'd3;
            end
        end
        bcd_out = {bcd_adj[14:0], bin_in[W-1]};
        bin_out = {bin_in[W-2:0], 1'b0};
    end

endmodule

// File: rtl/ssg_score_ctrl.sv
// Score sequencing controller: binary -> 4-digit BCD via sequential
// double-dabble, held digit registers and a registered dash overlay.
// Optional build macro SSG_CTRL_SAT_EN: saturate inputs above 9999 to 9999
// instead of showing dashes for an overflowed value.
module ssg_score_ctrl #(
    parameter int W = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         val_valid,
    output logic         val_ready,
    input  logic [W-1:0] val_data,
    input  logic         dash_req,
    output logic         busy,
    output logic         updated,
    output logic [3:0]   dig0,
    output logic [3:0]   dig1,
    output logic [3:0]   dig2,
    output logic [3:0]   dig3
);
    import ssg_pkg::*;

    localparam int CW = $clog2(W + 1);

    ssg_ctrl_state_t state;
    logic [CW-1:0]   cnt;
    logic [15:0]     bcd_q;
    logic [W-1:0]    bin_q;
    logic [15:0]     bcd_nx;
    logic [W-1:0]    bin_nx;
    bcd4_t           dig_q;
    logic            ovf_q;
    logic            xfer;
    logic            over_max;
    logic [W-1:0]    load_bin;

    assign xfer     = val_valid && val_ready;
    assign over_max = (32'(val_data) > 32'(BCD_MAX));

    // Value captured into the shift register at the transfer edge
    always_comb begin
`ifdef SSG_CTRL_SAT_EN
        load_bin = over_max ? W'(BCD_MAX) : val_data;
`else
        load_bin = val_data;
`endif
    end

    bcd_dabble_step #(.W(W)) u_step (
        .bcd_in  (bcd_q),
        .bin_in  (bin_q),
        .bcd_out (bcd_nx),
        .bin_out (bin_nx)
    );

    // Controller FSM with shift register, digit registers and handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            bcd_q     <= '0;
            bin_q     <= '0;
            dig_q     <= '0;
            ovf_q     <= 1'b0;
            val_ready <= 1'b1;
            busy      <= 1'b0;
            updated   <= 1'b0;
        end else begin
            updated <= 1'b0;
            case (state)
                IDLE: begin
                    if (xfer) begin
                        bin_q     <= load_bin;
                        bcd_q     <= '0;
                        cnt       <= '0;
`ifdef SSG_CTRL_SAT_EN
                        ovf_q     <= 1'b0;
`else
                        ovf_q     <= over_max;
`endif
                        val_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= CONV;
                    end
                end
                CONV: begin
                    bcd_q <= bcd_nx;
                    bin_q <= bin_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CW'(W - 1)) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
                    dig_q     <= ovf_q ? {4{DIGIT_DASH}} : bcd4_t'(bcd_q);
                    ovf_q     <= 1'b0;
                    updated   <= 1'b1;
                    val_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Registered dash overlay on the committed digits
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dig0 <= '0;
            dig1 <= '0;
            dig2 <= '0;
            dig3 <= '0;
        end else begin
            dig0 <= dash_req ? DIGIT_DASH : dig_q[0];
            dig1 <= dash_req ? DIGIT_DASH : dig_q[1];
            dig2 <= dash_req ? DIGIT_DASH : dig_q[2];
            dig3 <= dash_req ? DIGIT_DASH : dig_q[3];
        end
    end

endmodule

// File: tb/tb_ssg_score_ctrl.sv
// Self-checking bench for ssg_score_ctrl (W = 14).
module tb_ssg_score_ctrl;

    localparam int W = 14;
    localparam logic [15:0] DASHES = 16'hAAAA;
`ifdef SSG_CTRL_SAT_EN
    localparam logic [15:0] OVF_EXP = 16'h9999;
`else
    localparam logic [15:0] OVF_EXP = 16'hAAAA;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         val_valid;
    logic         val_ready;
    logic [W-1:0] val_data;
    logic         dash_req;
    logic         busy;
    logic         updated;
    logic [3:0]   dig0, dig1, dig2, dig3;
    logic [15:0]  digits;

    int n_chk = 0;
    int n_err = 0;
    logic [15:0] sb[$];
    logic [15:0] shown;

    assign digits = {dig3, dig2, dig1, dig0};

    ssg_score_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .val_valid (val_valid),
        .val_ready (val_ready),
        .val_data  (val_data),
        .dash_req  (dash_req),
        .busy      (busy),
        .updated   (updated),
        .dig0      (dig0),
        .dig1      (dig1),
        .dig2      (dig2),
        .dig3      (dig3)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int t = 0;
        while (!val_ready && t < 50) begin
            tick();
            t++;
        end
        chk("ready_wait", 32'(val_ready), 32'd1);
    endtask

    // One transfer; samples k = 0..W+2 after the transfer edge.
    task automatic do_xfer(input logic [W-1:0] v, input logic [15:0] exp,
                           input int dash_at, input int inject_at);
        int busy_cnt = 0;
        int upd_k    = -1;
        int upd_n    = 0;
        logic [15:0] exp_v;
        wait_ready();
        val_valid = 1'b1;
        val_data  = v;
        sb.push_back(exp);
        tick();
        val_valid = 1'b0;
        for (int k = 0; k <= W + 2; k++) begin
            if (k > 0) tick();
            if (busy) busy_cnt++;
            if (updated) begin
                upd_n++;
                if (upd_k < 0) upd_k = k;
            end
            if (inject_at >= 0 && k == inject_at + 1) begin
                val_valid = 1'b0;
                chk("ignored_ready_after", 32'(val_ready), 32'd0);
            end
            if (inject_at >= 0 && k == inject_at) begin
                chk("ignored_ready", 32'(val_ready), 32'd0);
                val_valid = 1'b1;
                val_data  = W'(42);
            end
            if (dash_at >= 0 && k == dash_at + 1) chk("dash_1clk", 32'(digits), 32'(DASHES));
            if (dash_at >= 0 && k == dash_at) dash_req = 1'b1;
            if (k == W + 1) chk("hold_before_commit", 32'(digits), 32'(dash_req ? DASHES : shown));
        end
        exp_v = sb.pop_front();
        chk("digits", 32'(digits), 32'(dash_req ? DASHES : exp_v));
        chk("updated_cycle", 32'(upd_k), 32'(W + 1));
        chk("updated_count", 32'(upd_n), 32'd1);
        chk("busy_cycles", 32'(busy_cnt), 32'(W + 1));
        chk("ready_after", 32'(val_ready), 32'd1);
        shown = exp_v;
    endtask

    initial begin
        int ready_k;
        int upd_n;
        rst_n     = 1'b0;
        val_valid = 1'b0;
        val_data  = '0;
        dash_req  = 1'b0;
        shown     = '0;
        tick();
        tick();
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_ready", 32'(val_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_updated", 32'(updated), 32'd0);
        rst_n = 1'b1;
        tick();

        do_xfer(W'(1234), 16'h1234, -1, -1);

        // Back-to-back 0 then 9999 with val_valid held high
        wait_ready();
        val_valid = 1'b1;
        val_data  = '0;
        sb.push_back(16'h0000);
        tick();
        val_data = W'(9999);
        sb.push_back(16'h9999);
        ready_k = -1;
        for (int k = 0; k <= W + 6; k++) begin
            if (k > 0) tick();
            if (val_ready) begin
                ready_k = k;
                break;
            end
        end
        chk("b2b_accept_edge", 32'(ready_k + 1), 32'(W + 2));
        tick();
        val_valid = 1'b0;
        chk("b2b_first", 32'(digits), 32'(sb.pop_front()));
        chk("b2b_second_busy", 32'(busy), 32'd1);
        repeat (W + 2) tick();
        chk("b2b_second", 32'(digits), 32'(sb.pop_front()));
        shown = 16'h9999;

        do_xfer(W'(12000), OVF_EXP, -1, -1);

        do_xfer(W'(507), 16'h0507, 5, -1);
        dash_req = 1'b0;
        tick();
        chk("dash_release", 32'(digits), 32'h0507);

        do_xfer(W'(77), 16'h0077, -1, 3);

        // Reset in the middle of converting 8888
        wait_ready();
        val_valid = 1'b1;
        val_data  = W'(8888);
        tick();
        val_valid = 1'b0;
        repeat (7) tick();
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_digits", 32'(digits), 32'd0);
        chk("mid_rst_ready", 32'(val_ready), 32'd1);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_updated", 32'(updated), 32'd0);
        tick();
        rst_n = 1'b1;
        upd_n = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (updated) upd_n++;
        end
        chk("post_rst_no_update", 32'(upd_n), 32'd0);
        chk("post_rst_digits", 32'(digits), 32'd0);
        shown = '0;

        do_xfer(W'(3), 16'h0003, -1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ssg_score_ctrl.md
# ssg_score_ctrl

Sequencing controller for the 4-digit seven-segment multiplexer. It accepts binary score values over a valid/ready handshake and converts each one to four BCD digits with a sequential double-dabble (one bit per clock). It holds the result stable on `dig0..dig3`, which wire directly to the display driver's `in0..in3`. It also applies a dash overlay that the game FSM uses for "no score / game over" screens.

## Interface
- `W`, 14: width of the binary input; legal range 4..14.
- `clk`  input  1  system clock (100 MHz).
- `rst_n`  input  1  asynchronous, active-low reset.
- `val_valid`  input  1  a new score value is presented.
- `val_ready`  output  1  controller can accept a value; high only in IDLE.
- `val_data`  input  W  binary score, unsigned.
- `dash_req`  input  1  level request: show dashes on all four digits.
- `busy`  output  1  conversion in progress.
- `updated`  output  1  one-cycle pulse when the digit registers load a new result.
- `dig0`, `dig1`, `dig2`, `dig3`  output  4 each  display codes for ones, tens, hundreds and thousands; values 0-9, or 4'hA = dash.

## Operation
- A transfer occurs on a rising edge with `val_valid && val_ready`.
- States:
  - IDLE: `val_ready`=1. A transfer moves to CONV.
  - CONV: W cycles. Each cycle, every BCD nibble ≥5 gets +3, then {bcd, bin} shifts left by 1. After W shifts, go to COMMIT.
  - COMMIT: one cycle. Load the digit registers, pulse `updated`, return to IDLE.
- Range check happens at transfer time: if `val_data` > 9999, the overflow path applies (see Configuration). For W ≤ 13 the check can never fire.
- Digit registers change only in COMMIT.
- Output overlay, registered:
  - next-cycle `digN` = 4'hA if `dash_req`, else the digit register value.
  - Deasserting `dash_req` restores the last committed value one cycle later.
- `dash_req` never stalls or aborts a conversion. A COMMIT that happens under the overlay still updates the digit registers and still pulses `updated`.
- `val_valid` outside IDLE is ignored; no queuing. A source must hold `val_valid` until it sees `val_ready`.
- Reset, including mid-conversion: abort and go to IDLE. Outputs: `dig0..dig3`=0, `val_ready`=1, `busy`=0, `updated`=0, internal shift register cleared.

## Timing
- Transfer edge is E0.
- CONV shifts on edges E1..EW.
- COMMIT loads the digit registers at EW+1; `updated` is high during the cycle after EW+1. Overlay outputs reflect the new digits at EW+2.
- `busy` is high from after E0 through the COMMIT cycle.
- `val_ready` is low during the same window. It is high again after EW+1, so back-to-back transfers are possible every W+2 cycles.
- Latency from transfer edge to visible digits with `dash_req`=0: W+2 clocks (16 for W=14).
- `dash_req` to dash visible: 1 clock.

## Configuration
- `SSG_CTRL_SAT_EN` defined: values > 9999 are replaced by 9999 at transfer; conversion and COMMIT proceed normally.
- Not defined:
  - Values > 9999 set an overflow flag. Conversion still runs its W cycles so timing is identical.
  - COMMIT loads 4'hA into all four digit registers. The flag is cleared at COMMIT.

## Structure
- Package `ssg_pkg` holds:
  - `DIGIT_DASH` = 4'hA
  - `BCD_MAX` = 14'd9999
  - the state enum `ssg_ctrl_state_t` {IDLE, CONV, COMMIT}
  - `bcd4_t` (4×4-bit packed digit array)
- One sub-module, `bcd_dabble_step`: combinational add-3-then-shift of the 16-bit BCD plus W-bit binary vector, instantiated once. The controller holds all sequential state: FSM, bit counter of $clog2(W+1) bits, shift register, digit registers, overflow flag.

## Test plan
- Reset, then transfer 1234 → `busy` high for 15 cycles; `updated` pulse; `dig3..dig0` = 1,2,3,4 exactly 16 clocks after the transfer edge.
- Transfer 0 and then 9999 back-to-back, with `val_valid` held high → second transfer accepted exactly W+2 cycles after the first; digits read 0,0,0,0 then 9,9,9,9.
- Transfer 12000 → with `SSG_CTRL_SAT_EN`, digits 9,9,9,9; without it, all digits 4'hA; identical latency in both builds.
- Assert `dash_req` mid-conversion of 507 → all digits 4'hA one cycle later; `updated` still pulses; releasing `dash_req` shows 0,5,0,7 one cycle later.
- Pulse `val_valid` with 42 during CONV → ignored; `val_ready` stays 0; digits hold the prior value.
- Assert `rst_n`=0 at CONV cycle 7 of value 8888 → all outputs return to reset values immediately; no `updated` pulse; next transfer of 3 yields 0,0,0,3.
